// File: rtl/huffman_decoder_if.sv
// Bus-side port of the Huffman decoder: Avalon-MM style strobes, write data,
// combinational read data and the two flow-status outputs.
interface huffman_decoder_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic        access_mode;
    logic        finalize;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        empty_out;
    logic        full_out;

    modport master (
        output chipselect, write, read, access_mode, finalize, writedata,
        input  readdata, empty_out, full_out
    );
    modport slave (
        input  chipselect, write, read, access_mode, finalize, writedata,
        output readdata, empty_out, full_out
    );
endinterface

// File: rtl/huffman_decoder.sv
// Bit-serial Huffman decoder: 64-entry code table compared in parallel against
// the growing accumulator, decoded symbols queued in a small FIFO for the bus.

module huffman_decoder_lane (
    input  logic       clock,
    input  logic       resetn,
    input  logic       lut_we,
    input  logic [3:0] wr_len,
    input  logic [7:0] wr_code,
    input  logic [7:0] acc_nx,
    input  logic [3:0] len_nx,
    output logic       hit
);
    logic [3:0] len_q;
    logic [7:0] code_q;
    logic [7:0] mask;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            len_q  <= '0;
            code_q <= '0;
        end else if (lut_we) begin
            len_q  <= wr_len;
            code_q <= wr_code;
        end
    end

    // Bits of acc above len are always zero, so only the code needs masking.
    assign mask = 8'((9'd1 << len_q) - 9'd1);
    assign hit  = (len_q != 4'd0) && (len_q == len_nx) && (acc_nx == (code_q & mask));
endmodule

module huffman_decoder #(
    parameter int SYM_FIFO_DEPTH = 16
) (
    input  logic             clock,
    input  logic             resetn,
    huffman_decoder_if.slave bus
);
    localparam int NUM_LANES = 64;
    localparam int AW        = $clog2(SYM_FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, DECODE, WAIT, STALL, DONE} state_t;

    state_t state, state_nx;

    logic        wr_en, rd_en, rd_q, rd_first;
    logic        lut_wr, tail_wr, data_wr, data_acc, stat_rd;
    logic [3:0]  lut_len;
    logic [5:0]  tail_val;
    logic [5:0]  tail_cnt;

    logic [31:0] hold_data;
    logic        hold_full, hold_last, hold_avail;

    logic [31:0] shreg;
    logic [5:0]  bits_left;
    logic        cur_last;
    logic [7:0]  acc, acc_nx;
    logic [3:0]  len, len_nx;

    logic [NUM_LANES-1:0] hits;
    logic        hit_any;
    logic [5:0]  hit_idx;

    logic        load_en, consume, done_act;
    logic        push, pop, nomatch_ev;
    logic        done, err_nomatch, err_partial, err_overflow;

    logic [5:0]    mem [SYM_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, fifo_empty;
    logic [7:0]    cnt8;

    logic unused_wd;
    assign unused_wd = ^bus.writedata[31:18];

    // Bus decode
    assign wr_en    = bus.chipselect && bus.write;
    assign rd_en    = bus.chipselect && bus.read;
    assign rd_first = rd_en && !rd_q;
    assign lut_wr   = wr_en && bus.access_mode && !bus.finalize;
    assign tail_wr  = wr_en && bus.access_mode && bus.finalize;
    assign data_wr  = wr_en && !bus.access_mode;
    // LOAD frees the holding register this cycle, so a write landing then is kept.
    assign data_acc = data_wr && (!hold_full || state == LOAD);
    assign stat_rd  = rd_first && bus.access_mode;
    assign pop      = rd_first && !bus.access_mode && !fifo_empty;
    assign lut_len  = (bus.writedata[9:6] > 4'd8) ? 4'd0 : bus.writedata[9:6];
    assign tail_val = bus.writedata[5:0];
    assign hold_avail = hold_full || data_acc;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_q     <= 1'b0;
            tail_cnt <= 6'd32;
        end else begin
            rd_q <= rd_en;
            if (tail_wr)
                tail_cnt <= (tail_val == 6'd0 || tail_val > 6'd32) ? 6'd32 : tail_val;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            hold_last <= 1'b0;
        end else if (data_acc) begin
            hold_data <= bus.writedata;
            hold_full <= 1'b1;
            hold_last <= bus.finalize;
        end else if (load_en) begin
            hold_full <= 1'b0;
        end
    end

    // Code table lanes
    assign acc_nx = {acc[6:0], shreg[31]};
    assign len_nx = len + 4'd1;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        huffman_decoder_lane u_lane (
            .clock   (clock),
            .resetn  (resetn),
            .lut_we  (lut_wr && (bus.writedata[5:0] == 6'(gi))),
            .wr_len  (lut_len),
            .wr_code (bus.writedata[17:10]),
            .acc_nx  (acc_nx),
            .len_nx  (len_nx),
            .hit     (hits[gi])
        );
    end

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_any = 1'b1;
                hit_idx = 6'(i);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (hold_avail) state_nx = LOAD;
            LOAD:   state_nx = DECODE;
            DECODE: begin
                if (fifo_full)
                    state_nx = STALL;
                else if (bits_left == 6'd1)
                    state_nx = hold_avail ? LOAD : (cur_last ? DONE : WAIT);
            end
            WAIT:   if (hold_avail) state_nx = LOAD;
            STALL:  if (!fifo_full) state_nx = DECODE;
            DONE:   if (hold_avail) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        load_en  = 1'b0;
        consume  = 1'b0;
        done_act = 1'b0;
        unique case (state)
            LOAD:    load_en  = 1'b1;
            DECODE:  consume  = !fifo_full;
            DONE:    done_act = 1'b1;
            default: ;
        endcase
    end

    assign push       = consume && hit_any;
    assign nomatch_ev = consume && !hit_any && (len_nx == 4'd8);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            shreg     <= '0;
            bits_left <= '0;
            cur_last  <= 1'b0;
            acc       <= '0;
            len       <= '0;
        end else if (load_en) begin
            shreg     <= hold_data;
            bits_left <= hold_last ? tail_cnt : 6'd32;
            cur_last  <= hold_last;
        end else if (consume) begin
            shreg     <= {shreg[30:0], 1'b0};
            bits_left <= bits_left - 6'd1;
            if (hit_any || len_nx == 4'd8) begin
                acc <= '0;
                len <= '0;
            end else begin
                acc <= acc_nx;
                len <= len_nx;
            end
        end else if (done_act) begin
            acc <= '0;
            len <= '0;
        end
    end

    // Sticky flags: a new event in the same cycle as a status read wins.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            done         <= 1'b0;
            err_nomatch  <= 1'b0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (stat_rd) begin
                err_nomatch  <= 1'b0;
                err_partial  <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (nomatch_ev)              err_nomatch  <= 1'b1;
            if (done_act && len != 4'd0) err_partial  <= 1'b1;
            if (data_wr && !data_acc)    err_overflow <= 1'b1;
            if (data_acc)      done <= 1'b0;
            else if (done_act) done <= 1'b1;
        end
    end

    // Symbol FIFO
    assign fifo_full  = (count == (AW+1)'(SYM_FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign cnt8       = 8'(count);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= hit_idx;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (rd_en) begin
            if (!bus.access_mode) begin
                if (!fifo_empty) bus.readdata = {26'b0, mem[rd_ptr]};
            end else begin
                bus.readdata = {16'b0, cnt8, 2'b0, err_overflow, err_partial,
                                err_nomatch, done, hold_full, fifo_empty};
            end
        end
    end

    assign bus.empty_out = fifo_empty;
    assign bus.full_out  = hold_full;
endmodule
